// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: BTB table owner with registered lookup, update FIFO with 2-bit counter training, and flush sweep
module btb_update_ctrl #(
  parameter int ENTRIES = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 11,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_req,
  input  logic [15:0] lookup_pc,
  output logic        lookup_hit,
  output logic [15:0] lookup_target,
  input  logic        resolve_valid,
  input  logic [15:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [15:0] resolve_target,
  output logic        resolve_ready,
  input  logic        flush,
  output logic        busy
);
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nx;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [15:0] tgt [ENTRIES];
  logic [1:0] ctr [ENTRIES];
  logic [15:0] q_pc [QDEPTH];
  logic [15:0] q_tgt [QDEPTH];
  logic [QDEPTH-1:0] q_tk;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [IDX_W-1:0] sweep, li, ui;
  logic [15:0] u_pc, u_tgt;
  logic u_tk, u_hit, l_hit, push, pop, go_flush, full;
  always_comb begin
    full = cnt == (PW+1)'(QDEPTH);
    go_flush = state == IDLE && flush;
    resolve_ready = !full && state == IDLE && !flush;
    push = resolve_valid && resolve_ready;
    pop = state == IDLE && !flush && cnt != '0;
    busy = state == FLUSH;
    u_pc = q_pc[rp];
    u_tgt = q_tgt[rp];
    u_tk = q_tk[rp];
    ui = u_pc[IDX_W-1:0];
    u_hit = valid[ui] && tag[ui] == u_pc[15:IDX_W];
    li = lookup_pc[IDX_W-1:0];
    l_hit = lookup_req && state == IDLE && valid[li] && tag[li] == lookup_pc[15:IDX_W] && ctr[li][1];
    state_nx = state == IDLE ? (flush ? FLUSH : IDLE) : (sweep == IDX_W'(ENTRIES-1) ? IDLE : FLUSH);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // a flush request empties the queue on the same edge, dropping any concurrent push
  always_ff @(posedge clk) begin
    if (reset || go_flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        q_pc[wp] <= resolve_pc;
        q_tgt[wp] <= resolve_target;
        q_tk[wp] <= resolve_taken;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // single write port: the sweep owns it in FLUSH, training otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      sweep <= '0;
    end else if (state == FLUSH) begin
      valid[sweep] <= 1'b0;
      sweep <= sweep + 1'b1;
    end else if (pop) begin
      if (u_hit) begin
        ctr[ui] <= u_tk ? (ctr[ui] == 2'd3 ? 2'd3 : ctr[ui] + 2'd1) : (ctr[ui] == 2'd0 ? 2'd0 : ctr[ui] - 2'd1);
        if (u_tk) tgt[ui] <= u_tgt;
      end else if (u_tk) begin
        valid[ui] <= 1'b1;
        tag[ui] <= u_pc[15:IDX_W];
        tgt[ui] <= u_tgt;
        ctr[ui] <= 2'd2;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_hit <= 1'b0;
      lookup_target <= 16'hFFFF;
    end else begin
      lookup_hit <= l_hit;
      lookup_target <= l_hit ? tgt[li] : 16'hFFFF;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed and random stimulus against a queue/array reference model of the BTB controller
module tb_btb_update_ctrl;
  localparam int ENTRIES = 32;
  localparam int QDEPTH = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic lookup_req = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
  logic [15:0] lookup_pc = '0, resolve_pc = '0, resolve_target = '0;
  logic lookup_hit, resolve_ready, busy;
  logic [15:0] lookup_target;
  int vecs = 0, errs = 0;
  typedef struct {logic [15:0] pc; logic tk; logic [15:0] tgt;} upd_t;
  upd_t q[$];
  bit mv [ENTRIES];
  int mtag [ENTRIES], mtgt [ENTRIES], mctr [ENTRIES];
  int flush_left = 0;
  logic exp_hit = 1'b0;
  logic [15:0] exp_tgt = 16'hFFFF;
  bit acc;
  btb_update_ctrl dut (
    .clk(clk), .reset(reset), .lookup_req(lookup_req), .lookup_pc(lookup_pc),
    .lookup_hit(lookup_hit), .lookup_target(lookup_target), .resolve_valid(resolve_valid),
    .resolve_pc(resolve_pc), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_ready(resolve_ready), .flush(flush), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic rq, input logic [15:0] lpc, input logic rv, input logic [15:0] rpc,
                      input logic rtk, input logic [15:0] rtg, input logic fl, input logic rs);
    logic er;
    int i, t;
    upd_t u;
    lookup_req = rq; lookup_pc = lpc; resolve_valid = rv; resolve_pc = rpc;
    resolve_taken = rtk; resolve_target = rtg; flush = fl; reset = rs;
    #1;
    er = q.size() < QDEPTH && flush_left == 0 && !fl;
    check("ready", resolve_ready, er);
    check("busy", busy, flush_left != 0);
    acc = rv && er;
    @(posedge clk);
    if (rs) begin
      foreach (mv[k]) mv[k] = 0;
      q.delete();
      flush_left = 0;
      exp_hit = 0;
      exp_tgt = 16'hFFFF;
    end else begin
      i = lpc[4:0];
      exp_hit = rq && flush_left == 0 && mv[i] && mtag[i] == int'(lpc[15:5]) && mctr[i] >= 2;
      exp_tgt = exp_hit ? 16'(mtgt[i]) : 16'hFFFF;
      if (flush_left != 0) begin
        mv[ENTRIES - flush_left] = 0;
        flush_left--;
      end else if (fl) begin
        flush_left = ENTRIES;
        q.delete();
      end else begin
        if (q.size() != 0) begin
          u = q.pop_front();
          i = u.pc[4:0];
          t = u.pc[15:5];
          if (mv[i] && mtag[i] == t) begin
            if (u.tk) begin
              mctr[i] = mctr[i] == 3 ? 3 : mctr[i] + 1;
              mtgt[i] = u.tgt;
            end else mctr[i] = mctr[i] == 0 ? 0 : mctr[i] - 1;
          end else if (u.tk) begin
            mv[i] = 1; mtag[i] = t; mtgt[i] = u.tgt; mctr[i] = 2;
          end
        end
        if (acc) q.push_back('{rpc, rtk, rtg});
      end
    end
    #1;
    check("hit", lookup_hit, exp_hit);
    check("target", lookup_target, exp_tgt);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic look(input logic [15:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
    int k = 0;
    do begin
      step(0, 0, 1, pc, tk, tg, 0, 0);
      k++;
    end while (!acc && k < 50);
    check("accept", 32'(acc), 1);
  endtask
  initial begin
    int busy_n;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    look(16'h0123);
    check("rst_hit", lookup_hit, 0);
    check("rst_tgt", lookup_target, 16'hFFFF);
    check("rst_busy", busy, 0);
    resolve(16'h0123, 1, 16'h0400);
    idle(2);
    look(16'h0123);
    check("alloc_hit", lookup_hit, 1);
    check("alloc_tgt", lookup_target, 16'h0400);
    look(16'h0523);
    check("tagmiss_hit", lookup_hit, 0);
    check("tagmiss_tgt", lookup_target, 16'hFFFF);
    resolve(16'h0123, 0, 16'h0);
    idle(2);
    look(16'h0123);
    check("ctr1_hit", lookup_hit, 0);
    for (int k = 0; k < 3; k++) resolve(16'h0123, 1, 16'h0400);
    resolve(16'h0123, 0, 16'h0);
    idle(2);
    look(16'h0123);
    check("ctr2_hit", lookup_hit, 1);
    check("ctr2_tgt", lookup_target, 16'h0400);
    resolve(16'h1001, 1, 16'hA001);
    resolve(16'h2002, 1, 16'hA002);
    resolve(16'h3003, 1, 16'hA003);
    idle(2);
    look(16'h1001); check("bp1", lookup_target, 16'hA001);
    look(16'h2002); check("bp2", lookup_target, 16'hA002);
    look(16'h3003); check("bp3", lookup_target, 16'hA003);
    resolve(16'h0000, 1, 16'hB000);
    resolve(16'h0005, 1, 16'hB005);
    resolve(16'h001F, 1, 16'hB01F);
    idle(2);
    look(16'h001F); check("pre_flush", lookup_target, 16'hB01F);
    step(0, 0, 1, 16'h0007, 1, 16'hC007, 1, 0);
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_n++;
      step(1, 16'(k % 32), 1, 16'h0009, 1, 16'hC009, k == 12, 0);
    end
    check("busy_cycles", busy_n, 32);
    look(16'h0000); check("fl0", lookup_target, 16'hFFFF);
    look(16'h0005); check("fl5", lookup_target, 16'hFFFF);
    look(16'h001F); check("fl31", lookup_target, 16'hFFFF);
    idle(3);
    resolve(16'h0004, 1, 16'hD004);
    resolve(16'h001E, 1, 16'hD01E);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(10);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", resolve_ready, 1);
    look(16'h001E); check("rst_mid_31", lookup_target, 16'hFFFF);
    look(16'h0004); check("rst_mid_4", lookup_hit, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] lpc, rpc;
      lpc = {14'($urandom_range(0, 3)), 2'b00} << 3 | 16'($urandom_range(0, 7));
      rpc = {14'($urandom_range(0, 3)), 2'b00} << 3 | 16'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 2) != 0), rpc,
           1'($urandom_range(0, 3) != 0), 16'($urandom), $urandom_range(0, 59) == 0,
           $urandom_range(0, 299) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
